i_serdes_word_align: RTL
========================

# i_serdes_word_align

Automatic word-alignment controller for one or more I_SERDES receive channels. After a START request, each channel's parallel output is compared against a known training pattern. On a mismatch the block drives BITSLIP_ADJ pulses until the pattern appears for a required number of consecutive words. It then reports per-channel lock or error. It sits in the CLK_IN domain directly behind the I_SERDES instances and replaces manual bitslip sequencing.

## Interface
- WIDTH, 4, deserialisation ratio per channel; legal range 3..10.
- NUM_CH, 1, number of channels aligned independently; legal range 1..8.
- TRAIN_PATTERN, 10'h00A, training word; only bits [WIDTH-1:0] are compared.
- MATCH_CNT, 4, consecutive matching valid words required to lock; legal range 1..15.
- SETTLE_CYC, 3, valid words discarded after each slip pulse before checking resumes.
- SLIP_PULSE, 2, BITSLIP_ADJ high time in CLK_IN cycles.

Ports:
- CLK_IN  in  1  word clock (same clock as the I_SERDES CLK_IN).
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request to (re)start training on all channels.
- Q_IN  in  NUM_CH*WIDTH  parallel words; channel c uses bits [c*WIDTH +: WIDTH].
- DATA_VALID_IN  in  NUM_CH  per-channel word-valid qualifier from I_SERDES.
- BITSLIP_ADJ  out  NUM_CH  per-channel bitslip request to I_SERDES.
- ALIGNED  out  NUM_CH  channel locked on the pattern.
- ALIGN_ERROR  out  NUM_CH  channel exhausted all slip positions without locking.
- SLIP_COUNT  out  NUM_CH*4  slips issued per channel in the current training run.
- DONE  out  1  every channel is in LOCKED or ERROR.

## Operation
- There is one FSM per channel with states IDLE, CHECK, SLIP, SETTLE, LOCKED and ERROR. All channels share START.
- **IDLE:** outputs are low. START moves the FSM to CHECK and clears the match counter and slip counter.
- **CHECK:** only cycles with DATA_VALID_IN[c]=1 are evaluated; the FSM holds otherwise.
  - Word equals the pattern: increment the match count. When the count reaches MATCH_CNT, move to LOCKED.
  - Word does not equal the pattern: clear the match count.
    - If slip count = WIDTH, move to ERROR.
    - Otherwise move to SLIP.
- **SLIP:** BITSLIP_ADJ[c]=1 for exactly SLIP_PULSE cycles, independent of DATA_VALID_IN. Slip count is incremented on entry. The FSM then moves to SETTLE.
- **SETTLE:** discard SETTLE_CYC valid words, then return to CHECK.
- **LOCKED:** ALIGNED[c]=1 and the state is held. Later data is ignored.
- **ERROR:** ALIGN_ERROR[c]=1 and the state is held.
- START from any state (including mid-SLIP) aborts and restarts at CHECK with counters cleared. An in-progress BITSLIP_ADJ pulse is dropped the cycle after START.
- SLIP_COUNT saturates at 15. It is only meaningful up to WIDTH slips.
- DONE is the AND over channels of (LOCKED or ERROR). It is 0 in IDLE.
- Channels progress independently. One channel's slips never affect another.

## Timing
- All outputs are registered.
- Reset value of every output is 0, and every FSM resets to IDLE.
- Mismatch sampled on cycle n: BITSLIP_ADJ rises at n+1 and falls at n+1+SLIP_PULSE.
- The MATCH_CNT-th consecutive match sampled on cycle n: ALIGNED rises at n+1.
- START on cycle n: state is CHECK at n+1, and ALIGNED, ALIGN_ERROR, SLIP_COUNT and DONE are 0 at n+1.
- Best-case lock latency: MATCH_CNT valid words plus 1 cycle.
- Worst-case ERROR latency: WIDTH*(1 + SLIP_PULSE + SETTLE_CYC words) plus 1 word.
- RST asserted mid-training: outputs clear asynchronously. BITSLIP_ADJ must not glitch high on RST release.

## Test plan
The bench models I_SERDES behaviourally: each BITSLIP_ADJ rising edge rotates the channel's word right by one bit.
- **Aligned start:** WIDTH=4, pattern 4'hA, input 4'hA every cycle, START → ALIGNED=1 after 4 valid words, SLIP_COUNT=0, DONE=1, no BITSLIP_ADJ pulse.
- **One-slip lock:** input 4'h5 at start → one 2-cycle BITSLIP_ADJ pulse, then 3 words discarded, then lock. SLIP_COUNT=1, ALIGNED=1.
- **Unreachable pattern:** input constant 4'hF → 4 slips, then ALIGN_ERROR=1, ALIGNED=0, SLIP_COUNT=4, DONE=1.
- **Independent channels:** NUM_CH=2; ch0 aligned, ch1 needs 3 slips → ch0 locks with 0 slips, ch1 with SLIP_COUNT=3; DONE rises only after ch1 locks.
- **Valid gaps:** DATA_VALID_IN toggling 1/0 during CHECK → lock requires 4 valid words; match count is not reset by invalid cycles.
- **Mid-operation disturbances:** START pulsed during SLIP → pulse drops next cycle, counters clear, retraining completes. Separately, RST pulsed mid-SETTLE → all outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/i_serdes_word_align.sv
// i_serdes_word_align
//
// Automatic word-alignment controller for NUM_CH I_SERDES receive channels.
// Each channel has its own FSM. It compares the channel's parallel word with
// TRAIN_PATTERN and issues BITSLIP_ADJ pulses until the pattern is seen on
// MATCH_CNT consecutive valid words. The FSM then reports lock. If no slip
// position produces the pattern, the FSM reports an error instead. The block
// runs in the CLK_IN domain, directly behind the I_SERDES instances.
//
// Ports:
//   CLK_IN         word clock, the same clock as the I_SERDES CLK_IN
//   RST            asynchronous active-high reset
//   START          single-cycle request to (re)start training on all channels
//   Q_IN           parallel words; channel c uses bits [c*WIDTH +: WIDTH]
//   DATA_VALID_IN  per-channel word-valid qualifier
//   BITSLIP_ADJ    per-channel bitslip request, SLIP_PULSE cycles wide
//   ALIGNED        channel locked on the training pattern
//   ALIGN_ERROR    channel tried every slip position without locking
//   SLIP_COUNT     slips issued per channel in this run, 4 bits per channel
//   DONE           every channel is either LOCKED or ERROR
//
// All outputs are registered and reset to 0.

module i_serdes_word_align #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned NUM_CH        = 1,
    parameter logic [9:0]  TRAIN_PATTERN = 10'h00A,
    parameter int unsigned MATCH_CNT     = 4,
    parameter int unsigned SETTLE_CYC    = 3,
    parameter int unsigned SLIP_PULSE    = 2
) (
    input  logic                    CLK_IN,
    input  logic                    RST,
    input  logic                    START,
    input  logic [NUM_CH*WIDTH-1:0] Q_IN,
    input  logic [NUM_CH-1:0]       DATA_VALID_IN,
    output logic [NUM_CH-1:0]       BITSLIP_ADJ,
    output logic [NUM_CH-1:0]       ALIGNED,
    output logic [NUM_CH-1:0]       ALIGN_ERROR,
    output logic [NUM_CH*4-1:0]     SLIP_COUNT,
    output logic                    DONE
);

    localparam int unsigned CntW = 8;

    localparam logic [WIDTH-1:0] Pattern    = TRAIN_PATTERN[WIDTH-1:0];
    localparam logic [3:0]       MatchLast  = 4'((MATCH_CNT > 0) ? MATCH_CNT - 1 : 0);
    localparam logic [3:0]       MaxSlips   = 4'(WIDTH);
    localparam logic [CntW-1:0]  PulseLast  = CntW'((SLIP_PULSE > 0) ? SLIP_PULSE - 1 : 0);
    localparam logic [CntW-1:0]  SettleLast = CntW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CntW-1:0]  CntOne     = CntW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSlip,
        StSettle,
        StLocked,
        StError
    } state_e;

    // Per-channel "finished" flags, taken from the next state so that DONE
    // updates on the same edge as ALIGNED and ALIGN_ERROR.
    logic [NUM_CH-1:0] term_d;
    logic              done_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [3:0]       match_q, match_d;
        logic [3:0]       slip_q, slip_d;
        logic [CntW-1:0]  pulse_q, pulse_d;
        logic [CntW-1:0]  settle_q, settle_d;
        logic             bitslip_q, bitslip_d;
        logic             aligned_q, aligned_d;
        logic             error_q, error_d;
        logic [WIDTH-1:0] word;
        logic             valid;
        logic             is_match;

        assign word     = Q_IN[c*WIDTH +: WIDTH];
        assign valid    = DATA_VALID_IN[c];
        assign is_match = (word == Pattern);

        // State, counter and output registers.
        always_ff @(posedge CLK_IN or posedge RST) begin
            if (RST) begin
                state_q   <= StIdle;
                match_q   <= '0;
                slip_q    <= '0;
                pulse_q   <= '0;
                settle_q  <= '0;
                bitslip_q <= 1'b0;
                aligned_q <= 1'b0;
                error_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                match_q   <= match_d;
                slip_q    <= slip_d;
                pulse_q   <= pulse_d;
                settle_q  <= settle_d;
                bitslip_q <= bitslip_d;
                aligned_q <= aligned_d;
                error_q   <= error_d;
            end
        end

        // Next-state and counter logic.
        always_comb begin
            state_d  = state_q;
            match_d  = match_q;
            slip_d   = slip_q;
            pulse_d  = pulse_q;
            settle_d = settle_q;

            if (START) begin
                // START overrides every state, including a pulse in progress.
                state_d  = StCheck;
                match_d  = '0;
                slip_d   = '0;
                pulse_d  = '0;
                settle_d = '0;
            end else begin
                unique case (state_q)
                    StCheck: begin
                        if (valid) begin
                            if (is_match) begin
                                match_d = match_q + 4'd1;
                                if (match_q == MatchLast) begin
                                    state_d = StLocked;
                                end
                            end else begin
                                match_d = '0;
                                if (slip_q == MaxSlips) begin
                                    state_d = StError;
                                end else begin
                                    state_d = StSlip;
                                    pulse_d = '0;
                                    if (slip_q != 4'd15) begin
                                        slip_d = slip_q + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                    StSlip: begin
                        // The pulse width does not depend on DATA_VALID_IN.
                        if (pulse_q == PulseLast) begin
                            pulse_d  = '0;
                            settle_d = '0;
                            state_d  = (SETTLE_CYC == 0) ? StCheck : StSettle;
                        end else begin
                            pulse_d = pulse_q + CntOne;
                        end
                    end
                    StSettle: begin
                        // Only valid words count toward the settle window.
                        if (valid) begin
                            if (settle_q == SettleLast) begin
                                settle_d = '0;
                                state_d  = StCheck;
                            end else begin
                                settle_d = settle_q + CntOne;
                            end
                        end
                    end
                    StIdle, StLocked, StError: begin
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        // Outputs are decoded from the next state and then registered.
        always_comb begin
            bitslip_d = (state_d == StSlip);
            aligned_d = (state_d == StLocked);
            error_d   = (state_d == StError);
        end

        assign term_d[c]             = aligned_d | error_d;
        assign BITSLIP_ADJ[c]        = bitslip_q;
        assign ALIGNED[c]            = aligned_q;
        assign ALIGN_ERROR[c]        = error_q;
        assign SLIP_COUNT[c*4 +: 4]  = slip_q;
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            done_q <= 1'b0;
        end else begin
            done_q <= &term_d;
        end
    end

    assign DONE = done_q;

endmodule
